// File: rtl/uart_pkg.sv
// Shared receive-FSM encoding, register offsets and STATUS layout for the J1 UART.
// Latency: n/a (types only). Backpressure: n/a.
// Also provides the 3-sample majority vote used for bit decisions.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  localparam int STAT_AVAIL   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVERRUN = 2;
  localparam int STAT_FRAME   = 3;
  localparam int STAT_PARITY  = 4;

  // Field order matches the STATUS bit indices above (avail is bit 0).
  typedef struct packed {
    logic parity_err;
    logic frame_err;
    logic overrun;
    logic full;
    logic avail;
  } status_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO, first-word-fall-through (dout shows the head while !empty).
// Latency: a push is visible at dout the cycle after it is written.
// Backpressure: push ignored when full unless a pop lands on the same cycle; pop ignored when empty.
module sync_fifo #(
  parameter int WIDTH   = 8,
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   dout,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   count
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               wr_en;
  logic               rd_en;

  assign empty = (count == '0);
  assign full  = (count == (FIFO_AW + 1)'(DEPTH));
  assign rd_en = pop & ~empty;
  // A pop frees the head slot this cycle, so a full FIFO can still accept.
  assign wr_en = push & (~full | rd_en);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// J1 UART receiver: 8N1 (8E1 with UART_RX_PARITY_EN), 16x oversampling, majority vote, byte FIFO.
// Latency: byte pushed at the stop-bit centre; DATA/STATUS reads return on d_out one cycle after rd.
// Backpressure: none on the line; a byte arriving with the FIFO full is dropped and overrun is set.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int FIFO_AW  = 4
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        uart_rx,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic        addr,
  input  logic [15:0] d_in,
  output logic [15:0] d_out,
  output logic        rx_irq
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  logic [1:0]       sync_q;
  logic             rx_s;
  logic             rx_prev;
  logic             start_edge;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  rx_state_t        state;
  rx_state_t        state_nxt;
  logic [3:0]       tcnt;
  logic             s7;
  logic             s8;
  logic             maj;
  logic             samp_pt;
  logic [2:0]       bit_cnt;
  logic [7:0]       rx_byte_dat;
  logic             rx_byte_vld;
  logic             frame_err_set;

  logic             rd_data;
  logic             rd_stat;
  logic             wr_stat;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_dout;
  logic [FIFO_AW:0] fifo_count;

  logic             frame_err;
  logic             overrun;
  status_t          status;

  assign rx_s       = sync_q[1];
  assign start_edge = rx_prev & ~rx_s;

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      sync_q  <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], uart_rx};
      rx_prev <= rx_s;
    end
  end

  assign tick = (div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) div_cnt <= '0;
    else            div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end

  // Samples 7 and 8 are latched; sample 9 is the live input at the decision tick.
  assign maj     = maj3(s7, s8, rx_s);
  assign samp_pt = tick && (tcnt == 4'd9);

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  logic parity_err;
  logic parity_err_set;
`endif

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    rx_byte_vld   = 1'b0;
    frame_err_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_set = 1'b0;
`endif
    case (state)
      ST_IDLE:  if (start_edge) state_nxt = ST_START;
      ST_START: if (samp_pt) state_nxt = maj ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (samp_pt && bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = ST_PARITY;
`else
          state_nxt = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (samp_pt) begin
          state_nxt      = ST_STOP;
          parity_err_set = (maj != ^rx_byte_dat);
        end
      end
`endif
      ST_STOP: begin
        if (samp_pt) begin
          state_nxt = ST_IDLE;
          if (!maj) frame_err_set = 1'b1;
`ifdef UART_RX_PARITY_EN
          else      rx_byte_vld   = ~par_bad;
`else
          else      rx_byte_vld   = 1'b1;
`endif
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      tcnt        <= '0;
      s7          <= 1'b1;
      s8          <= 1'b1;
      bit_cnt     <= '0;
      rx_byte_dat <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad     <= 1'b0;
`endif
    end else begin
      if (state == ST_IDLE) begin
        tcnt    <= '0;
        bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
        par_bad <= 1'b0;
`endif
      end else if (tick) begin
        tcnt <= tcnt + 1'b1;
      end
      if (tick && tcnt == 4'd7) s7 <= rx_s;
      if (tick && tcnt == 4'd8) s8 <= rx_s;
      if (state == ST_DATA && samp_pt) begin
        rx_byte_dat <= {maj, rx_byte_dat[7:1]};
        bit_cnt     <= bit_cnt + 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      if (parity_err_set) par_bad <= 1'b1;
`endif
    end
  end

  assign rd_data = cs & rd & (addr == ADDR_DATA);
  assign rd_stat = cs & rd & (addr == ADDR_STATUS);
  assign wr_stat = cs & wr & (addr == ADDR_STATUS);

  sync_fifo #(
    .WIDTH   (8),
    .FIFO_AW (FIFO_AW)
  ) u_rx_fifo (
    .clk   (sys_clk_i),
    .rst_n (sys_rst_i),
    .push  (rx_byte_vld),
    .pop   (rd_data),
    .din   (rx_byte_dat),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Set beats clear when both happen on the same cycle, so no event is lost.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (wr_stat && d_in[STAT_FRAME]) begin
        frame_err <= 1'b0;
        overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err <= 1'b0;
`endif
      end
      if (frame_err_set) frame_err <= 1'b1;
      if (rx_byte_vld && fifo_full && !rd_data) overrun <= 1'b1;
`ifdef UART_RX_PARITY_EN
      if (parity_err_set) parity_err <= 1'b1;
`endif
    end
  end

  always_comb begin
    status           = '0;
`ifdef UART_RX_PARITY_EN
    status.parity_err = parity_err;
`endif
    status.frame_err = frame_err;
    status.overrun   = overrun;
    status.full      = fifo_full;
    status.avail     = ~fifo_empty;
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i)   d_out <= '0;
    else if (rd_data) d_out <= fifo_empty ? 16'h0000 : {8'h00, fifo_dout};
    else if (rd_stat) d_out <= {11'b0, status};
  end

  assign rx_irq = ~fifo_empty;

  logic unused_bits;
  assign unused_bits = ^{d_in[15:4], d_in[2:0], fifo_count};

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit, with a queue-based receive model.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_rx;
  logic        cs, rd, wr, addr;
  logic [15:0] d_in;
  logic [15:0] d_out;
  logic        rx_irq;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  mq[$];
  logic        m_frame, m_over, m_par;
  logic [15:0] m_dout;
  logic        busy, chk_en;
  logic [15:0] v;

  uart_rx_fifo #(
    .CLK_FREQ (1_600_000),
    .BAUD     (100_000),
    .FIFO_AW  (4)
  ) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst_n),
    .uart_rx   (uart_rx),
    .cs        (cs),
    .rd        (rd),
    .wr        (wr),
    .addr      (addr),
    .d_in      (d_in),
    .d_out     (d_out),
    .rx_irq    (rx_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] m_status();
    return {11'b0, m_par, m_frame, m_over, mq.size() == 16, mq.size() != 0};
  endfunction

  task automatic bus_read(input logic a, output logic [15:0] val);
    cs = 1'b1; rd = 1'b1; addr = a;
    if (a == 1'b0) m_dout = (mq.size() != 0) ? {8'h00, mq.pop_front()} : 16'h0000;
    else           m_dout = m_status();
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    val = d_out;
  endtask

  task automatic bus_write(input logic a, input logic [15:0] data);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = data;
    if (a == 1'b1 && data[3]) begin
      m_frame = 1'b0; m_over = 1'b0; m_par = 1'b0;
    end
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; d_in = 16'h0000;
  endtask

  // Drives one frame starting at the current negedge; the model learns the byte's fate at the end.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    logic par_bad;
    busy = 1'b1;
    par_bad = 1'b0;
    uart_rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (16) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    uart_rx = (^b) ^ par_flip;
    par_bad = par_flip;
    repeat (16) @(negedge clk);
`endif
    uart_rx = stop_bit;
    repeat (16) @(negedge clk);
    uart_rx = 1'b1;
    if (!stop_bit)            m_frame = 1'b1;
    else if (par_bad)         m_par = 1'b1;
    else if (mq.size() == 16) m_over = 1'b1;
    else                      mq.push_back(b);
    busy = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (chk_en && !busy) begin
        check("cyc_irq", {15'b0, rx_irq}, {15'b0, mq.size() != 0});
        check("cyc_dout", d_out, m_dout);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int frame_len;
    rst_n = 1'b0; uart_rx = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 1'b0; d_in = 16'h0000;
    m_frame = 1'b0; m_over = 1'b0; m_par = 1'b0; m_dout = 16'h0000;
    busy = 1'b0; chk_en = 1'b0;
`ifdef UART_RX_PARITY_EN
    frame_len = 176;
`else
    frame_len = 160;
`endif

    repeat (3) @(negedge clk);
    check("rst_dout", d_out, 16'h0000);
    check("rst_irq", {15'b0, rx_irq}, 16'h0000);
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte, then empty-FIFO DATA read and an ignored DATA write.
    send_frame(8'h55, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    bus_read(1'b1, v); check("t1_stat_pre", v, 16'h0001);
    check("t1_irq_pre", {15'b0, rx_irq}, 16'h0001);
    bus_read(1'b0, v); check("t1_data", v, 16'h0055);
    bus_read(1'b1, v); check("t1_stat_post", v, 16'h0000);
    check("t1_irq_post", {15'b0, rx_irq}, 16'h0000);
    bus_read(1'b0, v); check("empty_read", v, 16'h0000);
    bus_write(1'b0, 16'h00FF);
    bus_read(1'b1, v); check("data_wr_ignored", v, 16'h0000);

    // Short low glitch must be rejected, and a real frame right after must still land.
    busy = 1'b1;
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (12) @(negedge clk);
    busy = 1'b0;
    send_frame(8'h96, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    bus_read(1'b0, v); check("post_glitch_data", v, 16'h0096);
    bus_read(1'b1, v); check("glitch_stat", v, 16'h0000);

    // Framing error then flag clear.
    send_frame(8'hA3, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    bus_read(1'b1, v); check("ferr_stat", v, 16'h0008);
    check("ferr_irq", {15'b0, rx_irq}, 16'h0000);
    bus_write(1'b1, 16'h0008);
    bus_read(1'b1, v); check("ferr_cleared", v, 16'h0000);

    // Overflow: 17 bytes into a 16-deep FIFO.
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    bus_read(1'b1, v); check("ovf_stat", v, 16'h0007);
    for (int i = 0; i < 16; i++) begin
      bus_read(1'b0, v); check("ovf_data", v, 16'(i));
    end
    bus_read(1'b1, v); check("ovf_stat_drained", v, 16'h0004);
    bus_write(1'b1, 16'h0008);

    // 15 buffered, then the 16th push coincides with a DATA read (push at clock frame_len-3).
    for (int i = 0; i < 15; i++) send_frame(8'h20 + 8'(i), 1'b1, 1'b0);
    fork
      send_frame(8'h2F, 1'b1, 1'b0);
      begin
        logic [15:0] rv;
        repeat (frame_len - 4) @(negedge clk);
        bus_read(1'b0, rv);
        check("simul_data", rv, 16'h0020);
      end
    join
    repeat (2) @(negedge clk);
    bus_read(1'b1, v); check("simul_stat", v, 16'h0001);
    for (int i = 0; i < 15; i++) begin
      bus_read(1'b0, v); check("simul_drain", v, 16'h0021 + 16'(i));
    end
    bus_read(1'b1, v); check("simul_stat_empty", v, 16'h0000);

    // Reset in bit 4 of 0xC6 with a byte buffered and STATUS on d_out.
    send_frame(8'h77, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    bus_read(1'b1, v); check("prerst_stat", v, 16'h0001);
    busy = 1'b1;
    uart_rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rx = v[0] ^ v[0] ^ ((8'hC6 >> i) & 8'h01) != 8'h00;
      repeat (16) @(negedge clk);
    end
    uart_rx = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    uart_rx = 1'b1;
    #1;
    check("midrst_dout", d_out, 16'h0000);
    check("midrst_irq", {15'b0, rx_irq}, 16'h0000);
    mq.delete();
    m_frame = 1'b0; m_over = 1'b0; m_par = 1'b0; m_dout = 16'h0000;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    busy = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    bus_read(1'b0, v); check("postrst_data", v, 16'h003C);
    bus_read(1'b1, v); check("postrst_stat", v, 16'h0000);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h3C, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    bus_read(1'b1, v); check("par_stat", v, 16'h0010);
    bus_write(1'b1, 16'h0008);
    bus_read(1'b1, v); check("par_cleared", v, 16'h0000);
`endif

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
